// File: rtl/prefetch_store_buffer.sv
// Store buffer behind the prefetcher: captures prefetcher writes, answers
// store-buffer reads with youngest-match forwarding, and drains to memory in FIFO order.
module prefetch_store_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   w_en,
  input  logic [AW-1:0]          w_addr,
  input  logic [DW-1:0]          w_data,
  output logic                   full_o,
  output logic                   overflow_o,
  output logic [$clog2(DEPTH):0] count_o,
  input  logic                   rd_req_i,
  input  logic [AW-1:0]          rd_addr_i,
  output logic                   wait_o,
  output logic                   data_ready_o,
  output logic [DW-1:0]          data_o,
  output logic                   hit_o,
  output logic                   drain_valid_o,
  output logic [AW-1:0]          drain_addr_o,
  output logic [DW-1:0]          drain_data_o,
  input  logic                   drain_ack_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [AW-1:0] r_rd_addr;
  logic          r_wait;
  logic          r_data_ready;
  logic          r_hit;
  logic [DW-1:0] r_data;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_drain_valid;
  logic          w_hit;
  logic [DW-1:0] w_hit_data;
  logic [PW-1:0] w_idx;

  assign w_full        = (r_count == FULL_CNT);
  assign w_push        = w_en && !w_full;
  // Drain is frozen during LOOKUP so the compared entry set cannot shift.
  assign w_drain_valid = (r_count != '0) && (r_state != S_LOOKUP);
  assign w_pop         = w_drain_valid && drain_ack_i;

  assign full_o        = w_full;
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
  assign drain_valid_o = w_drain_valid;
  assign drain_addr_o  = r_mem_addr[r_head];
  assign drain_data_o  = r_mem_data[r_head];
  assign wait_o        = r_wait;
  assign data_ready_o  = r_data_ready;
  assign hit_o         = r_hit;
  assign data_o        = r_data;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_addr[i] <= '0;
        r_mem_data[i] <= '0;
      end
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_addr[r_tail] <= w_addr;
        r_mem_data[r_tail] <= w_data;
        r_tail             <= r_tail + 1'b1;
      end
      if (w_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_idx      = r_head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_mem_addr[w_idx] == r_rd_addr)) begin
        w_hit      = 1'b1;
        w_hit_data = r_mem_data[w_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (rd_req_i) w_state_next = S_LOOKUP;
      S_LOOKUP: w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Registered read-port outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_addr    <= '0;
      r_wait       <= 1'b0;
      r_data_ready <= 1'b0;
      r_hit        <= 1'b0;
      r_data       <= '0;
    end else begin
      r_wait       <= (w_state_next == S_LOOKUP);
      r_data_ready <= (w_state_next == S_RESP);
      if ((r_state == S_IDLE) && rd_req_i) begin
        r_rd_addr <= rd_addr_i;
      end
      if (r_state == S_LOOKUP) begin
        r_hit  <= w_hit;
        r_data <= w_hit_data;
      end else if (r_state == S_RESP) begin
        r_hit  <= 1'b0;
        r_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prefetch_store_buffer.sv
// Directed bench for prefetch_store_buffer: fill/overflow/drain, forwarding hits
// and misses, drain freeze during lookup, pointer wrap, and async reset mid-lookup.
module tb_prefetch_store_buffer;

  logic        clk;
  logic        reset;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        full_o;
  logic        overflow_o;
  logic [3:0]  count_o;
  logic        rd_req_i;
  logic [31:0] rd_addr_i;
  logic        wait_o;
  logic        data_ready_o;
  logic [31:0] data_o;
  logic        hit_o;
  logic        drain_valid_o;
  logic [31:0] drain_addr_o;
  logic [31:0] drain_data_o;
  logic        drain_ack_i;

  int checks;
  int failures;

  prefetch_store_buffer #(.DEPTH(8), .AW(32), .DW(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .w_en          (w_en),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .full_o        (full_o),
    .overflow_o    (overflow_o),
    .count_o       (count_o),
    .rd_req_i      (rd_req_i),
    .rd_addr_i     (rd_addr_i),
    .wait_o        (wait_o),
    .data_ready_o  (data_ready_o),
    .data_o        (data_o),
    .hit_o         (hit_o),
    .drain_valid_o (drain_valid_o),
    .drain_addr_o  (drain_addr_o),
    .drain_data_o  (drain_data_o),
    .drain_ack_i   (drain_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_full"},     32'(full_o), 32'h0);
    chk({tag, "_ovf"},      32'(overflow_o), 32'h0);
    chk({tag, "_count"},    32'(count_o), 32'h0);
    chk({tag, "_wait"},     32'(wait_o), 32'h0);
    chk({tag, "_dready"},   32'(data_ready_o), 32'h0);
    chk({tag, "_data"},     data_o, 32'h0);
    chk({tag, "_hit"},      32'(hit_o), 32'h0);
    chk({tag, "_dvalid"},   32'(drain_valid_o), 32'h0);
    chk({tag, "_daddr"},    drain_addr_o, 32'h0);
    chk({tag, "_ddata"},    drain_data_o, 32'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    w_en = 1'b0; w_addr = '0; w_data = '0;
    rd_req_i = 1'b0; rd_addr_i = '0; drain_ack_i = 1'b0;

    repeat (2) @(negedge clk);
    chk_zero_outputs("rst");
    reset = 1'b0;

    // Fill to full with no drain
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; w_addr = 32'h100 + 32'(i); w_data = 32'hA0 + 32'(i);
      @(negedge clk);
    end
    chk("fill_full", 32'(full_o), 32'h1);
    chk("fill_count", 32'(count_o), 32'h8);
    chk("fill_ovf_pre", 32'(overflow_o), 32'h0);
    chk("fill_head", drain_addr_o, 32'h100);
    w_addr = 32'h108; w_data = 32'hA8;
    @(negedge clk);
    w_en = 1'b0;
    chk("ovf_set", 32'(overflow_o), 32'h1);
    chk("ovf_count", 32'(count_o), 32'h8);

    // Drain in FIFO order
    drain_ack_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(drain_valid_o), 32'h1);
      chk("drain_addr", drain_addr_o, 32'h100 + 32'(i));
      chk("drain_data", drain_data_o, 32'hA0 + 32'(i));
      @(negedge clk);
    end
    chk("drained_count", 32'(count_o), 32'h0);
    chk("drained_valid", 32'(drain_valid_o), 32'h0);
    chk("drained_full", 32'(full_o), 32'h0);
    chk("ovf_sticky", 32'(overflow_o), 32'h1);
    drain_ack_i = 1'b0;

    // Youngest-match forwarding
    w_en = 1'b1; w_addr = 32'h200; w_data = 32'h11;
    @(negedge clk);
    w_data = 32'h22;
    @(negedge clk);
    w_en = 1'b0;
    rd_req_i = 1'b1; rd_addr_i = 32'h200;
    @(negedge clk);
    rd_req_i = 1'b0;
    chk("ym_wait", 32'(wait_o), 32'h1);
    chk("ym_dready_early", 32'(data_ready_o), 32'h0);
    @(negedge clk);
    chk("ym_dready", 32'(data_ready_o), 32'h1);
    chk("ym_hit", 32'(hit_o), 32'h1);
    chk("ym_data", data_o, 32'h22);
    chk("ym_wait_off", 32'(wait_o), 32'h0);
    @(negedge clk);
    chk("ym_dready_off", 32'(data_ready_o), 32'h0);
    drain_ack_i = 1'b1;
    repeat (2) @(negedge clk);
    drain_ack_i = 1'b0;
    chk("ym_drained", 32'(count_o), 32'h0);

    // Miss on empty buffer
    rd_req_i = 1'b1; rd_addr_i = 32'h300;
    @(negedge clk);
    rd_req_i = 1'b0;
    chk("miss_wait", 32'(wait_o), 32'h1);
    @(negedge clk);
    chk("miss_dready", 32'(data_ready_o), 32'h1);
    chk("miss_hit", 32'(hit_o), 32'h0);
    chk("miss_data", data_o, 32'h0);
    @(negedge clk);

    // Write and request in the same cycle: lookup sees the new entry
    w_en = 1'b1; w_addr = 32'h400; w_data = 32'h55;
    rd_req_i = 1'b1; rd_addr_i = 32'h400;
    @(negedge clk);
    w_en = 1'b0; rd_req_i = 1'b0;
    @(negedge clk);
    chk("same_dready", 32'(data_ready_o), 32'h1);
    chk("same_hit", 32'(hit_o), 32'h1);
    chk("same_data", data_o, 32'h55);
    drain_ack_i = 1'b1;
    @(negedge clk);
    drain_ack_i = 1'b0;
    chk("same_drained", 32'(count_o), 32'h0);

    // Drain freeze during LOOKUP (pointers now at 3)
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1; w_addr = 32'h500 + 32'(i); w_data = 32'h50 + 32'(i);
      @(negedge clk);
    end
    w_en = 1'b0;
    chk("frz_count3", 32'(count_o), 32'h3);
    drain_ack_i = 1'b1;
    rd_req_i = 1'b1; rd_addr_i = 32'h501;
    @(negedge clk);
    rd_req_i = 1'b0;
    chk("frz_lookup_valid", 32'(drain_valid_o), 32'h0);
    chk("frz_lookup_count", 32'(count_o), 32'h2);
    chk("frz_lookup_wait", 32'(wait_o), 32'h1);
    @(negedge clk);
    chk("frz_resp_count", 32'(count_o), 32'h2);
    chk("frz_resp_valid", 32'(drain_valid_o), 32'h1);
    chk("frz_resp_hit", 32'(hit_o), 32'h1);
    chk("frz_resp_data", data_o, 32'h51);
    chk("frz_resp_head", drain_addr_o, 32'h501);
    @(negedge clk);
    chk("frz_count1", 32'(count_o), 32'h1);
    chk("frz_head2", drain_addr_o, 32'h502);
    @(negedge clk);
    chk("frz_count0", 32'(count_o), 32'h0);
    chk("frz_valid0", 32'(drain_valid_o), 32'h0);

    // Wrap with simultaneous write and pop (pointers at 6, wrap to 2)
    for (int i = 0; i < 4; i++) begin
      w_en = 1'b1; w_addr = 32'h600 + 32'(i); w_data = 32'h60 + 32'(i);
      @(negedge clk);
      chk("wrap_count", 32'(count_o), 32'h1);
      chk("wrap_addr", drain_addr_o, 32'h600 + 32'(i));
      chk("wrap_data", drain_data_o, 32'h60 + 32'(i));
    end
    w_en = 1'b0;
    @(negedge clk);
    drain_ack_i = 1'b0;
    chk("wrap_empty", 32'(count_o), 32'h0);

    // Full plus pop in the same cycle: write still dropped
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; w_addr = 32'h700 + 32'(i); w_data = 32'h70 + 32'(i);
      @(negedge clk);
    end
    w_addr = 32'h7FF; w_data = 32'hFF; drain_ack_i = 1'b1;
    @(negedge clk);
    w_en = 1'b0; drain_ack_i = 1'b0;
    chk("fullpop_count", 32'(count_o), 32'h7);
    chk("fullpop_full", 32'(full_o), 32'h0);
    chk("fullpop_head", drain_addr_o, 32'h701);
    drain_ack_i = 1'b1;
    repeat (2) @(negedge clk);
    drain_ack_i = 1'b0;
    chk("pre_rst_count", 32'(count_o), 32'h5);
    chk("pre_rst_head", drain_addr_o, 32'h703);

    // Async reset while in LOOKUP
    rd_req_i = 1'b1; rd_addr_i = 32'h705;
    @(negedge clk);
    rd_req_i = 1'b0;
    chk("arst_in_lookup", 32'(wait_o), 32'h1);
    #2 reset = 1'b1;
    #1 chk_zero_outputs("arst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_dready", 32'(data_ready_o), 32'h0);
      chk("arst_count", 32'(count_o), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
